// File: rtl/dataflow_branch_n.sv
// Registered N-way valid/ready outlet switch with sticky bad-select flag.
// Define DATAFLOW_BRANCH_BROADCAST_EN to add the i_broadcast input.
module dataflow_branch_n #(
  parameter int NUM_OUTPUTS  = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int SELECT_WIDTH = $clog2(NUM_OUTPUTS)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic [SELECT_WIDTH-1:0] i_select,
`ifdef DATAFLOW_BRANCH_BROADCAST_EN
  input  logic                    i_broadcast,
`endif
  output logic [NUM_OUTPUTS-1:0]  o_valid,
  input  logic [NUM_OUTPUTS-1:0]  o_ready,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_select_error
);

  logic [NUM_OUTPUTS-1:0] pend_q, pend_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   err_q, err_d;
  logic [NUM_OUTPUTS-1:0] sel_oh;
  logic                   in_range;
  logic                   bcast;
  logic                   accept;

`ifdef DATAFLOW_BRANCH_BROADCAST_EN
  assign bcast = i_broadcast;
`else
  assign bcast = 1'b0;
`endif

  // Any outlet still holding its bit blocks the whole branch.
  assign i_ready  = reset_n && ((pend_q & ~o_ready) == '0);
  assign accept   = i_valid && i_ready;
  assign in_range = 32'(i_select) < NUM_OUTPUTS;

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      sel_oh[i] = (32'(i_select) == i);
    end
  end

  always_comb begin
    pend_d = pend_q & ~o_ready;
    data_d = data_q;
    err_d  = err_q;
    if (accept) begin
      if (bcast) begin
        pend_d = '1;
        data_d = i_data;
      end else if (in_range) begin
        pend_d = sel_oh;
        data_d = i_data;
      end else begin
        pend_d = '0;
        err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  assign o_valid        = pend_q;
  assign o_data         = data_q;
  assign o_select_error = err_q;

endmodule
